// File: rtl/tick_sched_pkg.sv
// rtl/tick_sched_pkg.sv - shared types and constants for the tick scheduler
package tick_sched_pkg;

  // Hard ceiling on channel count; cfg_chan is sized to address all of them.
  localparam int MAX_CH    = 8;
  localparam int CHAN_W    = 3;
  localparam int DEF_CNT_W = 27;

  // Configuration handshake: IDLE accepts a request, APPLY writes it.
  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } cfg_state_t;

endpackage

// File: rtl/tick_channel.sv
// rtl/tick_channel.sv - one periodic tick generator with pause/sync control
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_period,
  input  logic             wr_enable,
  input  logic             pause,
  input  logic             sync,
  output logic             tick,
  output logic             active
);

  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] count_q;
  logic             enable_q;
  logic             tick_q;
  logic             active_q;
  logic             running;

  assign running = enable_q && (period_q != '0);

  // Counter, period store and registered tick; a write restarts the phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      period_q <= '0;
      count_q  <= '0;
      enable_q <= 1'b0;
      tick_q   <= 1'b0;
      active_q <= 1'b0;
    end else if (wr_en) begin
      period_q <= wr_period;
      enable_q <= wr_enable;
      count_q  <= '0;
      tick_q   <= 1'b0;
      active_q <= wr_enable && (wr_period != '0);
    end else if (!running) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else if (pause) begin
      // Hold the phase; the pending tick register is dropped so release
      // does not emit a stale pulse.
      tick_q <= 1'b0;
    end else if (sync) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else if (count_q >= period_q - CNT_W'(1)) begin
      // >= rather than == keeps the counter bounded even if a fault ever
      // left it above the wrap point.
      count_q <= '0;
      tick_q  <= 1'b1;
    end else begin
      count_q <= count_q + CNT_W'(1);
      tick_q  <= 1'b0;
    end
  end

  // Ticks are masked while the channel is being rewritten or paused.
  assign tick   = tick_q & ~wr_en & ~pause;
  assign active = active_q;

endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - multi-channel tick scheduler with config handshake
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CHAN_W-1:0] cfg_chan,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic              cfg_enable,
  input  logic              pause,
  input  logic              sync,
  output logic [NUM_CH-1:0] tick_out,
  output logic [NUM_CH-1:0] active_mask,
  output logic              cfg_err
);

  cfg_state_t        state_q;
  cfg_state_t        state_d;
  logic              apply;
  logic              accept;
  logic [CHAN_W-1:0] chan_q;
  logic [CNT_W-1:0]  period_q;
  logic              enable_q;
  logic              err_q;
  logic              chan_oor;

  // Config FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Config FSM next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    apply     = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          state_d = APPLY;
        end
      end
      APPLY: begin
        apply   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = cfg_valid && cfg_ready;

  // Capture the request on accept; it is written to a channel in APPLY.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chan_q   <= '0;
      period_q <= '0;
      enable_q <= 1'b0;
    end else if (accept) begin
      chan_q   <= cfg_chan;
      period_q <= cfg_period;
      enable_q <= cfg_enable;
    end
  end

  // Extra bit so NUM_CH=8 compares cleanly against a 3-bit index.
  assign chan_oor = ({1'b0, chan_q} >= 4'(NUM_CH));

  // Sticky flag for requests aimed at a channel that does not exist.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (apply && chan_oor) begin
      err_q <= 1'b1;
    end
  end

  assign cfg_err = err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .wr_en    (apply && (chan_q == CHAN_W'(i))),
      .wr_period(period_q),
      .wr_enable(enable_q),
      .pause    (pause),
      .sync     (sync),
      .tick     (tick_out[i]),
      .active   (active_mask[i])
    );
  end

endmodule
